// File: rtl/irq_priority_sequencer.sv
// Priority-interrupt front end: sticky A/B/C pending registers, per-channel enable
// masking, fixed-priority winner selection and a valid/ack grant handshake with timeout.

module irq_pend_level #(
   parameter int NCH = 9,
   parameter int CHW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] req,
   input  logic [NCH-1:0] clr,
   input  logic [NCH-1:0] en,
   output logic           any,
   output logic [CHW-1:0] first
);
   logic [NCH-1:0] pend;
   logic [NCH-1:0] elig;

   // Set beats clear, so a request landing on its own retire edge survives.
   always_ff @(posedge clk) begin
      if (rst) pend <= '0;
      else     pend <= (pend & ~clr) | req;
   end

   assign elig = pend & en;
   assign any  = |elig;

   always_comb begin
      first = '0;
      for (int i = NCH-1; i >= 0; i--)
         if (elig[i]) first = CHW'(i);
   end
endmodule

module irq_priority_sequencer #(
   parameter int NCH     = 9,
   parameter int TIMEOUT = 64,
   parameter int CNTW    = 7
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] en,
   input  logic [NCH-1:0] req_a,
   input  logic [NCH-1:0] req_b,
   input  logic [NCH-1:0] req_c,
   input  logic           irq_ack,
   input  logic           timeout_clr,
   output logic           irq_valid,
   output logic [3:0]     irq_chan,
   output logic [1:0]     irq_level,
   output logic           pa,
   output logic           pb,
   output logic           pc,
   output logic           busy,
   output logic           timeout_flag
);
   localparam int CHW = 4;
   localparam bit TO_EN = (TIMEOUT != 0);
   localparam logic [CNTW-1:0] TO_LAST = TO_EN ? CNTW'(TIMEOUT - 1) : '0;

   typedef enum logic {IDLE, WAIT_ACK} state_t;

   state_t                    state_q, state_d;
   logic [CHW-1:0]            chan_q, chan_d;
   logic [1:0]                lvl_q, lvl_d;
   logic [CNTW-1:0]           cnt_q, cnt_d;
   logic                      flag_q;
   logic                      set_to;

   logic [2:0][NCH-1:0]       req_all;
   logic [2:0][NCH-1:0]       clr_all;
   logic [2:0]                any_lvl;
   logic [2:0][CHW-1:0]       first_lvl;
   logic [CHW-1:0]            win_chan;
   logic [1:0]                win_lvl;

   assign req_all = {req_c, req_b, req_a};

   // Index 0 = level A, 1 = B, 2 = C.
   for (genvar l = 0; l < 3; l++) begin : g_lvl
      irq_pend_level #(.NCH(NCH), .CHW(CHW)) u_lvl (
         .clk   (clk),
         .rst   (rst),
         .req   (req_all[l]),
         .clr   (clr_all[l]),
         .en    (en),
         .any   (any_lvl[l]),
         .first (first_lvl[l])
      );
   end

   always_comb begin
      win_chan = '0;
      win_lvl  = 2'b00;
      if (any_lvl[0]) begin
         win_chan = first_lvl[0];
         win_lvl  = 2'b01;
      end else if (any_lvl[1]) begin
         win_chan = first_lvl[1];
         win_lvl  = 2'b10;
      end else if (any_lvl[2]) begin
         win_chan = first_lvl[2];
         win_lvl  = 2'b11;
      end
   end

   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      lvl_d   = lvl_q;
      cnt_d   = cnt_q;
      set_to  = 1'b0;
      clr_all = '0;
      case (state_q)
         IDLE: begin
            if (|any_lvl) begin
               state_d = WAIT_ACK;
               chan_d  = win_chan;
               lvl_d   = win_lvl;
               cnt_d   = '0;
            end
         end
         WAIT_ACK: begin
            if (irq_ack) begin
               clr_all[lvl_q - 2'd1][chan_q] = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else if (TO_EN && cnt_q == TO_LAST) begin
               // Abandon without clearing pending; the channel competes again.
               state_d = IDLE;
               cnt_d   = '0;
               set_to  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         chan_q  <= '0;
         lvl_q   <= 2'b00;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
         flag_q  <= set_to | (flag_q & ~timeout_clr);
      end
   end

   assign irq_valid    = (state_q == WAIT_ACK);
   assign busy         = (state_q == WAIT_ACK);
   assign irq_chan     = chan_q;
   assign irq_level    = (state_q == WAIT_ACK) ? lvl_q : 2'b00;
   assign pa           = any_lvl[0];
   assign pb           = any_lvl[1];
   assign pc           = any_lvl[2];
   assign timeout_flag = flag_q;
endmodule

// File: tb/tb_irq_priority_sequencer.sv
// Directed bench for irq_priority_sequencer, built with TIMEOUT=4.

module tb_irq_priority_sequencer;
   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] en, req_a, req_b, req_c;
   logic       irq_ack, timeout_clr;
   logic       irq_valid;
   logic [3:0] irq_chan;
   logic [1:0] irq_level;
   logic       pa, pb, pc, busy, timeout_flag;

   int vectors = 0;
   int miscompares = 0;

   irq_priority_sequencer #(.NCH(9), .TIMEOUT(4), .CNTW(3)) dut (
      .clk(clk), .rst(rst), .en(en), .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .irq_ack(irq_ack), .timeout_clr(timeout_clr), .irq_valid(irq_valid),
      .irq_chan(irq_chan), .irq_level(irq_level), .pa(pa), .pb(pb), .pc(pc),
      .busy(busy), .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_grant(input string tag, input logic v, input logic [3:0] ch, input logic [1:0] lv);
      chk({tag, ".valid"}, {31'd0, irq_valid}, {31'd0, v});
      chk({tag, ".busy"},  {31'd0, busy},      {31'd0, v});
      chk({tag, ".chan"},  {28'd0, irq_chan},  {28'd0, ch});
      chk({tag, ".level"}, {30'd0, irq_level}, {30'd0, lv});
   endtask

   initial begin
      // 1: reset with every input active
      rst = 1; en = 9'h1FF; req_a = 9'h1FF; req_b = 9'h1FF; req_c = 9'h1FF;
      irq_ack = 1; timeout_clr = 1;
      tick(); tick();
      chk_grant("rst", 1'b0, 4'd0, 2'b00);
      chk("rst.pa", {31'd0, pa}, 0);
      chk("rst.pb", {31'd0, pb}, 0);
      chk("rst.pc", {31'd0, pc}, 0);
      chk("rst.flag", {31'd0, timeout_flag}, 0);
      rst = 0; irq_ack = 0; timeout_clr = 0;
      tick();
      chk("post_rst1.valid", {31'd0, irq_valid}, 0);
      chk("post_rst1.pa", {31'd0, pa}, 1);
      chk("post_rst1.pc", {31'd0, pc}, 1);
      tick();
      chk_grant("post_rst2", 1'b1, 4'd0, 2'b01);
      req_a = 0; req_b = 0; req_c = 0; rst = 1;
      tick();
      chk_grant("rst_again", 1'b0, 4'd0, 2'b00);
      chk("rst_again.pa", {31'd0, pa}, 0);
      rst = 0;

      // 2: A beats B; lowest channel first within B; one-cycle gap
      req_b = 9'h030; req_a = 9'h100;
      tick();
      req_b = 0; req_a = 0;
      chk("t2.pend.valid", {31'd0, irq_valid}, 0);
      chk("t2.pend.pa", {31'd0, pa}, 1);
      chk("t2.pend.pb", {31'd0, pb}, 1);
      tick();
      chk_grant("t2.g1", 1'b1, 4'd8, 2'b01);
      irq_ack = 1; tick(); irq_ack = 0;
      chk_grant("t2.gap1", 1'b0, 4'd8, 2'b00);
      chk("t2.gap1.pa", {31'd0, pa}, 0);
      tick();
      chk_grant("t2.g2", 1'b1, 4'd4, 2'b10);
      irq_ack = 1; tick(); irq_ack = 0;
      chk_grant("t2.gap2", 1'b0, 4'd4, 2'b00);
      tick();
      chk_grant("t2.g3", 1'b1, 4'd5, 2'b10);
      irq_ack = 1; tick(); irq_ack = 0;
      tick();
      chk_grant("t2.idle", 1'b0, 4'd5, 2'b00);
      chk("t2.idle.pb", {31'd0, pb}, 0);

      // 3: request on a disabled channel waits for its enable
      en = 9'h0FE; req_a = 9'h001;
      tick(); req_a = 0;
      chk("t3.masked.pa", {31'd0, pa}, 0);
      tick();
      chk("t3.masked.valid", {31'd0, irq_valid}, 0);
      en = 9'h1FF;
      tick();
      chk_grant("t3.g", 1'b1, 4'd0, 2'b01);
      irq_ack = 1; tick(); irq_ack = 0;
      chk("t3.ret.valid", {31'd0, irq_valid}, 0);

      // 4: timeout after exactly 4 cycles high, re-grant, flag clear
      req_c = 9'h004;
      tick(); req_c = 0;
      tick();
      chk_grant("t4.c1", 1'b1, 4'd2, 2'b11);
      tick(); chk("t4.c2.valid", {31'd0, irq_valid}, 1);
      tick(); chk("t4.c3.valid", {31'd0, irq_valid}, 1);
      tick(); chk("t4.c4.valid", {31'd0, irq_valid}, 1);
      chk("t4.c4.flag", {31'd0, timeout_flag}, 0);
      tick();
      chk("t4.to.valid", {31'd0, irq_valid}, 0);
      chk("t4.to.flag", {31'd0, timeout_flag}, 1);
      chk("t4.to.pc", {31'd0, pc}, 1);
      tick();
      chk_grant("t4.regrant", 1'b1, 4'd2, 2'b11);
      chk("t4.regrant.flag", {31'd0, timeout_flag}, 1);
      timeout_clr = 1; irq_ack = 1;
      tick(); timeout_clr = 0; irq_ack = 0;
      chk("t4.clr.flag", {31'd0, timeout_flag}, 0);
      chk("t4.clr.valid", {31'd0, irq_valid}, 0);
      chk("t4.clr.pc", {31'd0, pc}, 0);

      // 5: request coinciding with ack survives; grant not pre-empted
      req_a = 9'h008;
      tick(); req_a = 0;
      tick();
      chk_grant("t5.g1", 1'b1, 4'd3, 2'b01);
      req_a = 9'h008; irq_ack = 1;
      tick(); req_a = 0; irq_ack = 0;
      chk("t5.ack.valid", {31'd0, irq_valid}, 0);
      chk("t5.ack.pa", {31'd0, pa}, 1);
      tick();
      chk_grant("t5.g2", 1'b1, 4'd3, 2'b01);
      req_a = 9'h001; en = 9'h1F7;
      tick(); req_a = 0; en = 9'h1FF;
      chk_grant("t5.hold", 1'b1, 4'd3, 2'b01);
      irq_ack = 1; tick(); irq_ack = 0;
      chk("t5.ret.valid", {31'd0, irq_valid}, 0);
      chk("t5.ret.pa", {31'd0, pa}, 1);
      tick();
      chk_grant("t5.g3", 1'b1, 4'd0, 2'b01);

      // 6: reset in the middle of a grant
      req_b = 9'h002;
      rst = 1;
      tick(); rst = 0; req_b = 0;
      chk_grant("t6.rst", 1'b0, 4'd0, 2'b00);
      chk("t6.rst.pb", {31'd0, pb}, 0);
      tick(); tick();
      chk("t6.after.valid", {31'd0, irq_valid}, 0);
      chk("t6.after.pa", {31'd0, pa}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
